// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helpers for the sync_fifo front-end.
//   FLAG_LAT : cycles between a FIFO write/read and its visibility in the
//              FIFO's full/empty flags
//   credit_w : width of a credit/level counter able to hold 0..depth
//   idx_w    : width of an index into n requesters
package sync_fifo_pkg;

    localparam int unsigned FLAG_LAT = 2;

    function automatic int unsigned credit_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: one-hot grant to the first set request
// at or above ptr, wrapping to the lowest set request.
//   req     : request vector
//   ptr     : highest-priority index this cycle
//   gnt     : one-hot grant (all zero when no request)
//   gnt_idx : binary index of the granted requester
module rr_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    logic [NREQ-1:0] masked;
    logic            found;

    // Masked pass first (indices >= ptr), then unmasked pass for the wrap.
    always_comb begin
        masked  = '0;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            masked[i] = req[i] && (IW'(i) >= ptr);
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && masked[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
                found   = 1'b1;
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!found && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo_arbiter.sv
// Round-robin write arbiter and read sequencer in front of one sync_fifo.
// Space/availability credits stand in for the FIFO's late full/empty flags.
//   clk, rst      : clock, synchronous active-high reset (shared with FIFO)
//   req_valid/data: NREQ producers, word i at req_data[i*WIDTH +: WIDTH]
//   req_ready     : combinational one-hot grant
//   cons_rd_req   : consumer read request (level)
//   cons_rd_valid : FIFO rdata holds a fresh word this cycle
//   fifo_wdata/wr_en/rd_en : registered FIFO controls
//   fifo_wr_err/rd_err     : FIFO error flags, folded into sticky err
//   level         : words written minus words read, as issued
module sync_fifo_arbiter
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NREQ  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*WIDTH-1:0]      req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic                       cons_rd_req,
    output logic                       cons_rd_valid,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic                       fifo_wr_en,
    output logic                       fifo_rd_en,
    input  logic                       fifo_wr_err,
    input  logic                       fifo_rd_err,
    output logic [credit_w(DEPTH)-1:0] level,
    output logic                       err
);

    localparam int unsigned CW = credit_w(DEPTH);
    localparam int unsigned IW = idx_w(NREQ);
    // Issue stages before a credit returns; stage 0 is the FIFO strobe itself.
    localparam int unsigned LW = FLAG_LAT - 1;

    logic [CW-1:0]    space_cr;
    logic [CW-1:0]    avail_cr;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    gnt_idx;
    logic [NREQ-1:0]  gnt;
    logic [LW-1:0]    wr_sr;
    logic [LW-1:0]    rd_sr;
    logic [WIDTH-1:0] wdata_sel;
    logic             xfer;
    logic             rd_issue;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grant only while space remains; gnt is already qualified by req_valid.
    assign req_ready  = (space_cr != '0) ? gnt : '0;
    assign xfer       = |req_ready;
    assign rd_issue   = cons_rd_req && (avail_cr != '0);
    assign fifo_wr_en = wr_sr[0];
    assign fifo_rd_en = rd_sr[0];

    // One-hot AND-OR mux of the winning producer's word.
    always_comb begin
        wdata_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (req_ready[i]) begin
                wdata_sel = wdata_sel | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Issue pipeline, credits, level and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sr         <= '0;
            rd_sr         <= '0;
            fifo_wdata    <= '0;
            rr_ptr        <= '0;
            space_cr      <= CW'(DEPTH);
            avail_cr      <= '0;
            level         <= '0;
            cons_rd_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            wr_sr <= LW'({wr_sr, xfer});
            rd_sr <= LW'({rd_sr, rd_issue});
            if (xfer) begin
                fifo_wdata <= wdata_sel;
                rr_ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
            end
            // A read returns space, and a write returns availability, only
            // once it has been on the FIFO port long enough for the flags.
            space_cr      <= space_cr - CW'(xfer) + CW'(rd_sr[LW-1]);
            avail_cr      <= avail_cr - CW'(rd_issue) + CW'(wr_sr[LW-1]);
            level         <= level + CW'(fifo_wr_en) - CW'(fifo_rd_en);
            cons_rd_valid <= fifo_rd_en;
            err           <= err | fifo_wr_err | fifo_rd_err;
        end
    end

endmodule
